// File: rtl/sched_pkg.sv
// Shared types for the delayed-write scheduler: operation and destination
// encodings plus the per-slot record held by each pending-write slot.
package sched_pkg;

    // Record fields are sized for the widest supported configuration;
    // slots zero-extend into them and read back only their own width.
    localparam int SCHED_MAX_W     = 32;
    localparam int SCHED_MAX_DLY_W = 16;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic {
        DEST_X = 1'b0,
        DEST_Y = 1'b1
    } dest_e;

    typedef struct packed {
        logic                       occupied;
        dest_e                      dest;
        logic [SCHED_MAX_W-1:0]     data;
        logic [SCHED_MAX_DLY_W-1:0] counter;
    } slot_rec_t;

endpackage

// File: rtl/sched_slot.sv
// One pending-write slot: loads a precomputed result with a countdown,
// counts down to zero (saturating), flags itself expired, and frees itself
// when the commit arbiter selects it.
module sched_slot
    import sched_pkg::*;
#(
    parameter int W     = 4,
    parameter int DLY_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  dest_e            load_dest,
    input  logic [W-1:0]     load_data,
    input  logic [DLY_W-1:0] load_delay,
    input  logic             clear,
    output logic             occupied,
    output logic             expired,
    output dest_e            dest,
    output logic [W-1:0]     data
);

    slot_rec_t rec_q;
    slot_rec_t rec_d;
    logic      unused_data_hi;

    // Next slot state: load beats clear (they never target the same slot),
    // otherwise an occupied slot counts down and holds at zero.
    always_comb begin
        rec_d = rec_q;
        if (load) begin
            rec_d.occupied = 1'b1;
            rec_d.dest     = load_dest;
            rec_d.data     = SCHED_MAX_W'(load_data);
            rec_d.counter  = SCHED_MAX_DLY_W'(load_delay);
        end else if (clear) begin
            rec_d.occupied = 1'b0;
            rec_d.counter  = '0;
        end else if (rec_q.occupied && (rec_q.counter != '0)) begin
            rec_d.counter = rec_q.counter - SCHED_MAX_DLY_W'(1);
        end
    end

    // Slot state register; reset frees the slot and clears its counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign occupied       = rec_q.occupied;
    assign expired        = rec_q.occupied && (rec_q.counter == '0);
    assign dest           = rec_q.dest;
    assign data           = rec_q.data[W-1:0];
    assign unused_data_hi = ^rec_q.data;

endmodule

// File: rtl/delay_write_sched.sv
// Delayed-write scheduler: requests compute their result at accept time,
// wait in a slot for a programmable number of cycles, then commit to x_q or
// y_q. One commit per cycle, lowest expired slot first; new requests go to
// the lowest free slot based on registered occupancy.
module delay_write_sched
    import sched_pkg::*;
#(
    parameter int NSLOTS = 4,
    parameter int W      = 4,
    parameter int DLY_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_dest,
    input  logic             req_op,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [DLY_W-1:0] req_delay,
    output logic             commit_valid,
    output logic             commit_dest,
    output logic [W-1:0]     commit_data,
    output logic [W-1:0]     x_q,
    output logic [W-1:0]     y_q,
    output logic             busy
);

    localparam int IDX_W = $clog2(NSLOTS);

    logic [NSLOTS-1:0] occ;
    logic [NSLOTS-1:0] exp_v;
    logic [NSLOTS-1:0] load_v;
    logic [NSLOTS-1:0] clear_v;
    dest_e             slot_dest [NSLOTS];
    logic [W-1:0]      slot_data [NSLOTS];

    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  win_idx;
    logic              has_free;
    logic              has_exp;
    logic              accept;
    dest_e             win_dest;
    logic [W-1:0]      win_data;
    logic [W-1:0]      req_result;

    // Result is modulo 2^W, so plain W-bit add/subtract wraps naturally.
    function automatic logic [W-1:0] calc_result(op_e op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            OP_SUB:  r = a - b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Free-slot priority encoder: lowest index whose occupied bit is clear.
    always_comb begin
        free_idx = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) free_idx = IDX_W'(i);
        end
    end

    // Commit arbiter: lowest-index expired slot wins; losers keep waiting.
    always_comb begin
        win_idx = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (exp_v[i]) win_idx = IDX_W'(i);
        end
    end

    assign has_free   = ~&occ;
    assign has_exp    = |exp_v;
    assign req_ready  = has_free;
    assign busy       = |occ;
    assign accept     = req_valid && has_free;
    assign req_result = calc_result(op_e'(req_op), req_a, req_b);
    assign win_dest   = slot_dest[win_idx];
    assign win_data   = slot_data[win_idx];

    for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
        assign load_v[g]  = accept && (free_idx == IDX_W'(g));
        assign clear_v[g] = has_exp && (win_idx == IDX_W'(g));

        sched_slot #(
            .W     (W),
            .DLY_W (DLY_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load_v[g]),
            .load_dest  (dest_e'(req_dest)),
            .load_data  (req_result),
            .load_delay (req_delay),
            .clear      (clear_v[g]),
            .occupied   (occ[g]),
            .expired    (exp_v[g]),
            .dest       (slot_dest[g]),
            .data       (slot_data[g])
        );
    end

    // Commit stage: register the winning write and update its destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_dest  <= 1'b0;
            commit_data  <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            commit_valid <= has_exp;
            if (has_exp) begin
                commit_dest <= win_dest;
                commit_data <= win_data;
                if (win_dest == DEST_Y) begin
                    y_q <= win_data;
                end else begin
                    x_q <= win_data;
                end
            end
        end
    end

endmodule
